// File: rtl/te_pkg.sv
// Shared types and sizing for the tracking-engine channel scheduler.
package te_pkg;

  localparam int PHYS_CH_NUM      = 4;
  localparam int LOGIC_CH_NUM_MAX = 32;
  localparam int CH_INDEX_W       = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIND,
    ST_FILL,
    ST_CORR,
    ST_DUMP,
    ST_DONE
  } te_state_e;

endpackage

// File: rtl/lowest_one_finder.sv
// Combinational priority encoder: index of the lowest set bit of a channel mask.
module lowest_one_finder
  import te_pkg::*;
(
  input  logic [LOGIC_CH_NUM_MAX-1:0] mask,
  output logic [CH_INDEX_W-1:0]       index,
  output logic                        valid
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    index = '0;
    valid = 1'b0;
    // Scan downwards so the lowest set bit is the last (winning) write.
    for (int i = LOGIC_CH_NUM_MAX - 1; i >= 0; i--) begin
      if (mask[i]) begin
        index = CH_INDEX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/te_channel_scheduler.sv
// Batches enabled logical channels onto 4 physical correlator slots and sequences fill/corr/dump.
// Optional sticky overrun flag enabled by defining TE_SCHED_OVERRUN_EN.
module te_channel_scheduler
  import te_pkg::*;
#(
  parameter int LOGIC_CH_NUM = 32
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   te_start,
  input  logic [31:0]            channel_enable,
  input  logic                   fill_state_done,
  input  logic                   corr_done,
  input  logic                   dump_state_done,
  output logic [PHYS_CH_NUM-1:0] physical_channel_en,
  output logic [CH_INDEX_W-1:0]  logic_channel_index0,
  output logic [CH_INDEX_W-1:0]  logic_channel_index1,
  output logic [CH_INDEX_W-1:0]  logic_channel_index2,
  output logic [CH_INDEX_W-1:0]  logic_channel_index3,
  output logic                   fill_start,
  output logic                   corr_start,
  output logic                   dump_start,
  output logic                   te_busy,
  output logic                   te_done,
  output logic                   te_overrun,
  input  logic                   overrun_clr
);

  localparam logic [LOGIC_CH_NUM_MAX-1:0] CH_MASK =
    LOGIC_CH_NUM_MAX'((64'd1 << LOGIC_CH_NUM) - 64'd1);

  te_state_e state_q, state_d;
  logic                                      entered_q;
  logic [LOGIC_CH_NUM_MAX-1:0]               pending_q;
  logic [2:0]                                k_q;
  logic [PHYS_CH_NUM-1:0]                    slot_en_q;
  logic [PHYS_CH_NUM-1:0][CH_INDEX_W-1:0]    slot_idx_q;

  logic [CH_INDEX_W-1:0]       found_idx;
  logic                        found_valid;
  logic [LOGIC_CH_NUM_MAX-1:0] pending_after;
  logic                        stage_done;

  lowest_one_finder u_finder (
    .mask  (pending_q),
    .index (found_idx),
    .valid (found_valid)
  );

  always_comb begin
    pending_after = pending_q;
    if (found_valid) pending_after[found_idx] = 1'b0;
  end

  // A done input only counts from the second cycle of its stage.
  always_comb begin
    stage_done = 1'b0;
    case (state_q)
      ST_FILL: stage_done = fill_state_done && !entered_q;
      ST_CORR: stage_done = corr_done && !entered_q;
      ST_DUMP: stage_done = dump_state_done && !entered_q;
      default: stage_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      // NOTE: sequential state is updated with <= so all registers see pre-edge values.
      state_q   <= ST_IDLE;
      entered_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      entered_q <= (state_d != state_q);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (te_start) state_d = ST_FIND;
      ST_FIND: begin
        if ((found_valid && k_q == 3'(PHYS_CH_NUM - 1)) || pending_after == '0)
          state_d = (found_valid || slot_en_q[0]) ? ST_FILL : ST_DONE;
      end
      ST_FILL: if (stage_done) state_d = ST_CORR;
      ST_CORR: if (stage_done) state_d = ST_DUMP;
      ST_DUMP: if (stage_done) state_d = ST_FIND;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pending_q  <= '0;
      k_q        <= '0;
      slot_en_q  <= '0;
      slot_idx_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (te_start) begin
            pending_q  <= channel_enable & CH_MASK;
            k_q        <= '0;
            slot_en_q  <= '0;
            slot_idx_q <= '0;
          end
        end
        ST_FIND: begin
          if (found_valid) begin
            slot_idx_q[k_q[1:0]] <= found_idx;
            slot_en_q[k_q[1:0]]  <= 1'b1;
            pending_q            <= pending_after;
            k_q                  <= k_q + 3'd1;
          end
        end
        ST_DUMP: begin
          if (stage_done) begin
            k_q        <= '0;
            slot_en_q  <= '0;
            slot_idx_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign physical_channel_en  = slot_en_q;
  assign logic_channel_index0 = slot_idx_q[0];
  assign logic_channel_index1 = slot_idx_q[1];
  assign logic_channel_index2 = slot_idx_q[2];
  assign logic_channel_index3 = slot_idx_q[3];

  assign fill_start = (state_q == ST_FILL) && entered_q;
  assign corr_start = (state_q == ST_CORR) && entered_q;
  assign dump_start = (state_q == ST_DUMP) && entered_q;
  assign te_busy    = (state_q != ST_IDLE);
  assign te_done    = (state_q == ST_DONE);

`ifdef TE_SCHED_OVERRUN_EN
  logic overrun_q;

  // Set has priority over clear so a coincident overrun is never lost.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                  overrun_q <= 1'b0;
    else if (te_start && te_busy) overrun_q <= 1'b1;
    else if (overrun_clr)        overrun_q <= 1'b0;
  end

  assign te_overrun = overrun_q;
`else
  logic unused_overrun_clr;

  assign unused_overrun_clr = overrun_clr;
  assign te_overrun         = 1'b0;
`endif

endmodule

// File: tb/tb_te_channel_scheduler.sv
// Directed self-checking bench for te_channel_scheduler (overrun expectation follows TE_SCHED_OVERRUN_EN).
module tb_te_channel_scheduler;

`ifdef TE_SCHED_OVERRUN_EN
  localparam logic OVR = 1'b1;
`else
  localparam logic OVR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_b;
  logic        te_start;
  logic [31:0] channel_enable;
  logic        fill_state_done, corr_done, dump_state_done;
  logic [3:0]  physical_channel_en;
  logic [4:0]  logic_channel_index0, logic_channel_index1;
  logic [4:0]  logic_channel_index2, logic_channel_index3;
  logic        fill_start, corr_start, dump_start;
  logic        te_busy, te_done, te_overrun, overrun_clr;

  int n_cmp = 0;
  int n_err = 0;

  te_channel_scheduler #(.LOGIC_CH_NUM(32)) dut (
    .clk                  (clk),
    .rst_b                (rst_b),
    .te_start             (te_start),
    .channel_enable       (channel_enable),
    .fill_state_done      (fill_state_done),
    .corr_done            (corr_done),
    .dump_state_done      (dump_state_done),
    .physical_channel_en  (physical_channel_en),
    .logic_channel_index0 (logic_channel_index0),
    .logic_channel_index1 (logic_channel_index1),
    .logic_channel_index2 (logic_channel_index2),
    .logic_channel_index3 (logic_channel_index3),
    .fill_start           (fill_start),
    .corr_start           (corr_start),
    .dump_start           (dump_start),
    .te_busy              (te_busy),
    .te_done              (te_done),
    .te_overrun           (te_overrun),
    .overrun_clr          (overrun_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_start(input int s);
    case (s)
      0:       return fill_start;
      1:       return corr_start;
      default: return dump_start;
    endcase
  endfunction

  function automatic logic get_next_start(input int s);
    case (s)
      0:       return corr_start;
      1:       return dump_start;
      default: return fill_start;
    endcase
  endfunction

  task automatic set_done(input int s, input logic v);
    case (s)
      0:       fill_state_done = v;
      1:       corr_done = v;
      default: dump_state_done = v;
    endcase
  endtask

  task automatic wait_start(input int s, input string tag, output int n);
    n = 0;
    while (!get_start(s) && n < 64) begin
      step();
      n++;
    end
    check({tag, " start seen"}, 32'(get_start(s)), 32'd1);
  endtask

  // Stage handshake: done is raised together with the start pulse (must be ignored),
  // held one more cycle (must be accepted). Optional te_start poke during the first cycle.
  task automatic stage(input int s, input string tag, input logic poke);
    int n;
    wait_start(s, tag, n);
    set_done(s, 1'b1);
    if (poke) te_start = 1'b1;
    step();
    te_start = 1'b0;
    check({tag, " held"}, {30'd0, get_start(s), get_next_start(s)}, 32'd0);
    step();
    set_done(s, 1'b0);
  endtask

  task automatic check_slots(input string tag, input logic [3:0] en,
                             input logic [4:0] i0, input logic [4:0] i1,
                             input logic [4:0] i2, input logic [4:0] i3);
    check({tag, " en"}, 32'(physical_channel_en), 32'(en));
    check({tag, " idx"}, {12'd0, logic_channel_index3, logic_channel_index2,
                          logic_channel_index1, logic_channel_index0},
                         {12'd0, i3, i2, i1, i0});
  endtask

  task automatic do_round(input string tag, input logic [3:0] en,
                          input logic [4:0] i0, input logic [4:0] i1,
                          input logic [4:0] i2, input logic [4:0] i3,
                          input logic poke_corr);
    int n;
    wait_start(0, tag, n);
    check_slots({tag, " alloc"}, en, i0, i1, i2, i3);
    stage(0, {tag, " fill"}, 1'b0);
    stage(1, {tag, " corr"}, poke_corr);
    check_slots({tag, " stable"}, en, i0, i1, i2, i3);
    stage(2, {tag, " dump"}, 1'b0);
    check_slots({tag, " cleared"}, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
    check({tag, " no done"}, 32'(te_done), 32'd0);
  endtask

  task automatic pulse_start(input logic [31:0] mask);
    channel_enable = mask;
    te_start       = 1'b1;
    step();
    te_start       = 1'b0;
  endtask

  task automatic expect_done(input string tag);
    step();
    check({tag, " te_done"}, 32'(te_done), 32'd1);
    step();
    check({tag, " idle"}, {30'd0, te_done, te_busy}, 32'd0);
  endtask

  initial begin
    int  n;
    logic seen_done;
    rst_b = 1'b0; te_start = 1'b0; channel_enable = '0; overrun_clr = 1'b0;
    fill_state_done = 1'b0; corr_done = 1'b0; dump_state_done = 1'b0;
    step();
    step();
    check("reset pulses", {27'd0, fill_start, corr_start, dump_start, te_done, te_busy}, 32'd0);
    check("reset overrun", 32'(te_overrun), 32'd0);
    check_slots("reset", 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
    rst_b = 1'b1;
    step();

    // Stray done inputs in IDLE do nothing.
    fill_state_done = 1'b1; corr_done = 1'b1; dump_state_done = 1'b1;
    step();
    fill_state_done = 1'b0; corr_done = 1'b0; dump_state_done = 1'b0;
    check("idle stray done", {28'd0, fill_start, corr_start, dump_start, te_busy}, 32'd0);

    // Empty mask: te_start cycle, FIND cycle, then DONE in the third cycle.
    pulse_start(32'h0000_0000);
    check("empty find", {29'd0, te_busy, te_done, fill_start}, 32'b100);
    step();
    check("empty done", {29'd0, te_busy, te_done, fill_start}, 32'b110);
    step();
    check("empty idle", {29'd0, te_busy, te_done, fill_start}, 32'b000);

    // Sparse mask: three FIND cycles allocate 0, 4, 31.
    pulse_start(32'h8000_0011);
    wait_start(0, "sparse", n);
    check("sparse find cycles", 32'(n), 32'd3);
    do_round("sparse", 4'b0111, 5'd0, 5'd4, 5'd31, 5'd0, 1'b0);
    expect_done("sparse");

    // Full mask: eight rounds of four consecutive channels.
    pulse_start(32'hFFFF_FFFF);
    for (int r = 0; r < 8; r++) begin
      do_round($sformatf("full r%0d", r), 4'b1111, 5'(4*r), 5'(4*r+1), 5'(4*r+2), 5'(4*r+3), 1'b0);
    end
    expect_done("full");

    // Five channels: 4 + 1.
    pulse_start(32'h0000_001F);
    do_round("five r0", 4'b1111, 5'd0, 5'd1, 5'd2, 5'd3, 1'b0);
    do_round("five r1", 4'b0001, 5'd4, 5'd0, 5'd0, 5'd0, 1'b0);
    expect_done("five");

    // te_start during CORR: pass unaffected, overrun per configuration.
    pulse_start(32'h0000_0100);
    do_round("ovr", 4'b0001, 5'd8, 5'd0, 5'd0, 5'd0, 1'b1);
    check("ovr sticky", 32'(te_overrun), 32'(OVR));
    expect_done("ovr");
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("ovr clr", 32'(te_overrun), 32'd0);

    // Coincident set and clear while busy: set wins.
    pulse_start(32'h0000_0001);
    te_start = 1'b1; overrun_clr = 1'b1;
    step();
    te_start = 1'b0; overrun_clr = 1'b0;
    check("ovr set wins", 32'(te_overrun), 32'(OVR));
    do_round("ovr2", 4'b0001, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    expect_done("ovr2");
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("ovr2 clr", 32'(te_overrun), 32'd0);

    // Enable mask changed during FILL has no effect on the running pass.
    pulse_start(32'h0000_0003);
    wait_start(0, "snap", n);
    channel_enable = 32'h0000_00F0;
    do_round("snap", 4'b0011, 5'd0, 5'd1, 5'd0, 5'd0, 1'b0);
    expect_done("snap");

    // Reset during DUMP aborts immediately with no te_done.
    pulse_start(32'h0000_0002);
    wait_start(0, "abort", n);
    stage(0, "abort fill", 1'b0);
    stage(1, "abort corr", 1'b0);
    check("abort in dump", 32'(dump_start), 32'd1);
    rst_b = 1'b0;
    #1;
    check("abort pulses", {27'd0, fill_start, corr_start, dump_start, te_done, te_busy}, 32'd0);
    check_slots("abort", 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) rst_b = 1'b1;
      step();
      seen_done |= te_done;
    end
    check("abort no done", 32'(seen_done), 32'd0);

    pulse_start(32'h0000_0006);
    do_round("post", 4'b0011, 5'd1, 5'd2, 5'd0, 5'd0, 1'b0);
    expect_done("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
